// File: rtl/general_addr_to_mask_pkg.sv
// Purpose: shared types and constants for the address-to-mask decoder and its encoder peer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package general_addr_to_mask_pkg;

    // Default geometry: a 40-entry flag vector addressed by 6-bit indices.
    localparam int DATA_NUM_DEF  = 40;
    localparam int NUM_WIDTH_DEF = 6;

    // Bit ordering convention shared with the first-set-bit encoder.
    localparam logic MODE_FWD = 1'b0;   // bit index = addr
    localparam logic MODE_REV = 1'b1;   // bit index = DATA_NUM-1-addr

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

endpackage

// File: rtl/general_addr_to_mask_if.sv
// Purpose: bundles the input beat stream and the completed-frame output of general_addr_to_mask.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the beat side, out_valid/out_ready on the frame side.
// Ports: mode, in_valid, in_ready, in_addr, in_last, out_valid, out_ready,
//        out_mask, out_count, out_dup, out_err.
interface general_addr_to_mask_if
    import general_addr_to_mask_pkg::*;
#(
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int NUM_WIDTH = NUM_WIDTH_DEF
);
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_WIDTH-1:0] in_addr;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_NUM-1:0]  out_mask;
    logic [NUM_WIDTH-1:0] out_count;
    logic                 out_dup;
    logic                 out_err;

    // Upstream producer and downstream consumer side.
    modport master (
        output mode, in_valid, in_addr, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_count, out_dup, out_err
    );

    // The decoder itself.
    modport slave (
        input  mode, in_valid, in_addr, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_count, out_dup, out_err
    );
endinterface

// File: rtl/general_addr_to_mask_onehot.sv
// Purpose: turn one address into a one-hot flag vector in forward or reverse bit order.
// Latency: combinational.
// Backpressure: none.
// Ports: addr (in), mode_eff (in), onehot (out, zero when out of range), range_err (out).
module general_addr_onehot
    import general_addr_to_mask_pkg::*;
#(
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
    input  logic [NUM_WIDTH-1:0] addr,
    input  logic                 mode_eff,
    output logic [DATA_NUM-1:0]  onehot,
    output logic                 range_err
);

    localparam logic [NUM_WIDTH-1:0] LIMIT    = NUM_WIDTH'(DATA_NUM);
    localparam logic [NUM_WIDTH-1:0] LAST_IDX = NUM_WIDTH'(DATA_NUM - 1);

    logic [NUM_WIDTH-1:0] idx;

    always_comb begin
        range_err = (addr >= LIMIT);
        // Reverse index is only meaningful in range; out-of-range addresses never set a bit.
        idx       = (mode_eff == MODE_REV) ? (LAST_IDX - addr) : addr;
        onehot    = '0;
        for (int i = 0; i < DATA_NUM; i++) begin
            onehot[i] = !range_err && (idx == NUM_WIDTH'(i));
        end
    end

endmodule

// File: rtl/general_addr_to_mask.sv
// Purpose: accumulate a stream of bit addresses into a flag vector with per-frame statistics.
// Latency: out_valid rises 1 cycle after the beat carrying in_last is accepted.
// Backpressure: in_ready is low while a completed frame waits; outputs hold until out_ready.
// Ports: clk, rst_n (async active-low), bus (slave modport: beat stream in, frame out).
module general_addr_to_mask
    import general_addr_to_mask_pkg::*;
#(
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    general_addr_to_mask_if.slave   bus
);

    state_e               state_q, state_d;
    logic [DATA_NUM-1:0]  mask_q,  mask_d;
    logic [NUM_WIDTH-1:0] count_q, count_d;
    logic                 dup_q,   dup_d;
    logic                 err_q,   err_d;
    logic                 first_q, first_d;
    logic                 mode_q,  mode_d;

    logic                 accept;
    logic                 mode_eff;
    logic [DATA_NUM-1:0]  onehot;
    logic                 range_err;
    logic                 hit;

    // The first beat of a frame decides the ordering for the whole frame.
    assign mode_eff = first_q ? bus.mode : mode_q;

    general_addr_onehot #(
        .DATA_NUM  (DATA_NUM),
        .NUM_WIDTH (NUM_WIDTH)
    ) u_onehot (
        .addr      (bus.in_addr),
        .mode_eff  (mode_eff),
        .onehot    (onehot),
        .range_err (range_err)
    );

    assign hit    = |(onehot & mask_q);
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
            mode_q  <= MODE_FWD;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            dup_q   <= dup_d;
            err_q   <= err_d;
            first_q <= first_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        count_d       = count_q;
        dup_d         = dup_q;
        err_d         = err_q;
        first_d       = first_q;
        mode_d        = mode_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        unique case (state_q)
            COLLECT: begin
                bus.in_ready = 1'b1;
                if (accept) begin
                    first_d = 1'b0;
                    mode_d  = mode_eff;
                    // Error, duplicate and fresh-set are mutually exclusive per beat.
                    if (range_err) begin
                        err_d = 1'b1;
                    end else if (hit) begin
                        dup_d = 1'b1;
                    end else begin
                        mask_d  = mask_q | onehot;
                        count_d = count_q + NUM_WIDTH'(1);
                    end
                    if (bus.in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    mask_d  = '0;
                    count_d = '0;
                    dup_d   = 1'b0;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Result fields come straight from the accumulator; consumers qualify with out_valid.
    assign bus.out_mask  = mask_q;
    assign bus.out_count = count_q;
    assign bus.out_dup   = dup_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_general_addr_to_mask.sv
module tb_general_addr_to_mask;
    import general_addr_to_mask_pkg::*;

    localparam int DN = 40;
    localparam int NW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    general_addr_to_mask_if #(.DATA_NUM(DN), .NUM_WIDTH(NW)) bus ();

    general_addr_to_mask #(.DATA_NUM(DN), .NUM_WIDTH(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int fr_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: a set of bit positions built directly from the frame's address list.
    task automatic model(input bit m, output logic [DN-1:0] msk, output int cnt,
                         output bit dup, output bit err);
        bit seen[int];
        msk = '0; cnt = 0; dup = 0; err = 0;
        foreach (fr_q[k]) begin
            int a = fr_q[k];
            int pos = m ? (DN - 1 - a) : a;
            if (a >= DN) err = 1;
            else if (seen.exists(pos)) dup = 1;
            else begin
                seen[pos] = 1;
                cnt++;
            end
        end
        foreach (seen[p]) msk[p] = 1'b1;
    endtask

    // First-set-bit encoder: forward scans from bit 0, reverse scans from the top bit.
    function automatic int enc(input logic [DN-1:0] v, input bit m);
        if (!m) begin
            for (int i = 0; i < DN; i++) if (v[i]) return i;
        end else begin
            for (int i = DN - 1; i >= 0; i--) if (v[i]) return DN - 1 - i;
        end
        return -1;
    endfunction

    // Sends every beat in fr_q; mode is m on the first beat and may flip afterwards.
    task automatic send_frame(input bit m, input bit toggle, input bit no_last);
        for (int k = 0; k < fr_q.size(); k++) begin
            int w = 0;
            bus.in_valid = 1'b1;
            bus.in_addr  = NW'(fr_q[k]);
            bus.in_last  = !no_last && (k == fr_q.size() - 1);
            bus.mode     = (k == 0) ? m : (toggle ? !m : m);
            while (!bus.in_ready && w < 50) begin
                @(posedge clk); #1; w++;
            end
            if (w >= 50) chk("beat_accept_timeout", 64'(0), 64'(1));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the last beat was accepted; optionally stalls before draining.
    task automatic check_frame(input bit m, input int stall);
        logic [DN-1:0] emask; int ecnt; bit edup, eerr;
        model(m, emask, ecnt, edup, eerr);
        @(negedge clk);
        chk("out_valid", 64'(bus.out_valid), 64'(1));
        chk("in_ready_drain", 64'(bus.in_ready), 64'(0));
        chk("out_mask", 64'(bus.out_mask), 64'(emask));
        chk("out_count", 64'(bus.out_count), 64'(ecnt));
        chk("out_dup", 64'(bus.out_dup), 64'(edup));
        chk("out_err", 64'(bus.out_err), 64'(eerr));
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_valid", 64'(bus.out_valid), 64'(1));
                chk("stall_mask", 64'(bus.out_mask), 64'(emask));
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_in_ready", 64'(bus.in_ready), 64'(1));
        chk("post_out_valid", 64'(bus.out_valid), 64'(0));
        chk("post_mask_clr", 64'(bus.out_mask), 64'(0));
        chk("post_count_clr", 64'(bus.out_count), 64'(0));
    endtask

    initial begin
        logic [DN-1:0] held_mask;
        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_addr = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b1;
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_mask", 64'(bus.out_mask), 64'(0));
        chk("rst_count", 64'(bus.out_count), 64'(0));
        chk("rst_flags", 64'({bus.out_dup, bus.out_err}), 64'(0));

        // Basic forward frame.
        fr_q = '{3, 7, 39};
        send_frame(1'b0, 1'b0, 1'b0);
        check_frame(1'b0, 0);

        // Reverse frame with mode flipping mid-frame.
        fr_q = '{0, 1};
        send_frame(1'b1, 1'b1, 1'b0);
        check_frame(1'b1, 0);

        // Duplicate and out-of-range beats.
        fr_q = '{5, 5, 45, 2};
        send_frame(1'b0, 1'b0, 1'b0);
        check_frame(1'b0, 0);

        // Backpressure: a beat offered during DRAIN must wait.
        bus.out_ready = 1'b0;
        fr_q = '{20};
        send_frame(1'b0, 1'b0, 1'b0);
        held_mask = '0; held_mask[20] = 1'b1;
        bus.in_valid = 1'b1; bus.in_addr = '0; bus.in_last = 1'b1; bus.mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            chk("bp_mask", 64'(bus.out_mask), 64'(held_mask));
            chk("bp_count", 64'(bus.out_count), 64'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        fr_q = '{0};
        check_frame(1'b0, 0);

        // Asynchronous reset in the middle of a frame.
        fr_q = '{12, 30};
        send_frame(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mask", 64'(bus.out_mask), 64'(0));
        chk("arst_count", 64'(bus.out_count), 64'(0));
        chk("arst_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        fr_q = '{10};
        send_frame(1'b0, 1'b0, 1'b0);
        check_frame(1'b0, 0);

        // Round trip through the encoder for every address in both orders.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < DN; a++) begin
                fr_q = '{a};
                send_frame(m[0], 1'b0, 1'b0);
                @(negedge clk);
                chk("roundtrip", 64'(enc(bus.out_mask, m[0])), 64'(a));
                @(negedge clk);
            end
        end

        // Random frames with random stalls and mid-frame mode noise.
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 8);
            bit m   = 1'($urandom_range(0, 1));
            bit tg  = 1'($urandom_range(0, 1));
            fr_q = {};
            for (int k = 0; k < len; k++) fr_q.push_back($urandom_range(0, 47));
            send_frame(m, tg, 1'b0);
            check_frame(m, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/general_addr_to_mask.md
Name: general_addr_to_mask

Overview:
- Inverse companion of the first-set-bit address encoder used across the PIM datapath.
- Accepts a stream of bit addresses, one per handshake, and accumulates them into a DATA_NUM-bit flag vector.
- Honours the same in-order / reverse-order convention as the encoder.
- Emits the completed vector, with per-frame statistics, through a valid/ready output handshake.

Parameters:
- DATA_NUM, 40, width of the flag vector.
- NUM_WIDTH, 6, address and count width; DATA_NUM < 2**NUM_WIDTH is required.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = in order (bit index = addr), 1 = reverse order (bit index = DATA_NUM-1-addr).
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_addr  input  NUM_WIDTH  address to set.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  completed frame available.
- out_ready  input  1  consumer accepts the frame.
- out_mask  output  DATA_NUM  accumulated flag vector.
- out_count  output  NUM_WIDTH  number of distinct bits set in out_mask.
- out_dup  output  1  at least one beat in the frame hit an already-set bit.
- out_err  output  1  at least one beat in the frame had in_addr >= DATA_NUM.

Behaviour:
- Reset (rst_n low, asynchronous), all registers cleared:
  - state = COLLECT, mask = 0, count = 0, dup = 0, err = 0, first = 1.
  - out_valid = 0, so in_ready = 1.
- State machine (two states):
  - COLLECT: in_ready = 1, out_valid = 0.
  - DRAIN: in_ready = 0, out_valid = 1.
- A beat is accepted when in_valid && in_ready.
- Mode latching:
  - On the first accepted beat of a frame (first = 1), mode is used directly and captured into mode_q; first then clears.
  - All later beats of the frame use mode_q.
  - Changes to mode mid-frame are ignored.
- Per accepted beat, idx = (mode_eff ? DATA_NUM-1-in_addr : in_addr). Exactly one of the following applies:
  - in_addr >= DATA_NUM: no bit is set, err <= 1, count unchanged.
  - mask[idx] already 1: dup <= 1, mask and count unchanged.
  - Otherwise: mask[idx] <= 1, count <= count + 1.
- Accepted beat with in_last = 1:
  - The beat's own update is applied in the same cycle, and state <= DRAIN.
  - out_valid rises on the next cycle (latency 1).
  - out_mask, out_count, out_dup and out_err already include the last beat.
- DRAIN:
  - Outputs stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: mask, count, dup and err clear to 0, first <= 1, state <= COLLECT. in_ready returns on the next cycle.
  - Maximum throughput is one frame per (beats + 1) cycles.
- in_valid while in DRAIN is not accepted; the upstream holds the beat.
- A frame may consist of a single beat with in_last = 1.
- No frame length limit. count cannot overflow because distinct bits ≤ DATA_NUM.
- Reset mid-frame or mid-DRAIN discards the partial or pending frame entirely; no output is produced for it.
- out_mask, out_count, out_dup and out_err are driven directly from registers and are visible in COLLECT as well. Consumers qualify them with out_valid.
- Round-trip property: for a frame of one in-range address a, feeding out_mask to the first-set-bit encoder in the same mode returns a.

Decomposition:
- Shared package:
  - State enum {COLLECT, DRAIN}.
  - Mode encoding constants MODE_FWD = 0 and MODE_REV = 1, shared with the encoder.
- One natural sub-module, general_addr_onehot (combinational). Inputs: addr, mode_eff. Outputs: a DATA_NUM-bit one-hot vector and a range-error flag.
- The top level holds the FSM, the accumulator, the counters, and the mode latch.

Test Plan:
- mode=0; beats 3, 7, 39(last); out_ready=1 -> the cycle after the last beat: out_valid=1, out_mask bits {3,7,39} set, out_count=3, out_dup=0, out_err=0. in_ready=0 for exactly that one cycle.
- mode=1 on the first beat; beats 0, 1(last); mode toggles to 0 mid-frame -> out_mask bits {39,38}, out_count=2 (mode latch honoured).
- Beats 5, 5, 45, 2(last) -> out_mask bits {5,2}, out_count=2, out_dup=1, out_err=1.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid -> outputs stable, in_ready=0, and an offered in_valid beat is not consumed. After out_ready=1: accumulator cleared, the next frame (single beat 0, last) gives out_mask = 1, out_count=1.
- Assert rst_n low asynchronously after 2 beats of a frame -> all outputs 0 immediately, in_ready=1. A subsequent single-beat frame (addr 10, last) yields only bit 10 set.
- Round-trip sweep: for each a in 0..39, with mode 0 and mode 1, a single-beat frame -> the encoder applied to out_mask in the same mode returns a.
